// File: rtl/key_press_gen.sv
// key_press_gen: drives an active-low emulated key through one press/release
// cycle per accepted request, with optional LFSR-timed contact bounce on both
// edges. Bounce timing is deterministic from reset.
module key_press_gen #(
    parameter logic [15:0] BOUNCE_CYC = 16'd500,
    parameter logic [3:0]  BOUNCE_N   = 4'd5,
    parameter logic [15:0] GAP_CYC    = 16'd1000,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        press_req,
    input  logic [24:0] hold_cyc,
    input  logic        bounce_en,
    output logic        ready,
    output logic        key_out,
    output logic        done,
    output logic [7:0]  press_cnt
);

    localparam int unsigned CNT_W  = 25;
    localparam int unsigned LFSR_W = 16;
    localparam int unsigned TICK_W = 4;
    localparam int unsigned TOG_W  = 5;
    localparam int unsigned PCNT_W = 8;

    // Window counters count down to zero, so each window loads length-1.
    localparam logic [CNT_W-1:0] BNC_LOAD = CNT_W'(BOUNCE_CYC) - CNT_W'(1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYC) - CNT_W'(1);
    // Even number of toggles per window returns the line to its entry level.
    localparam logic [TOG_W-1:0] TOG_MAX  = TOG_W'({BOUNCE_N, 1'b0});

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FALL_BNC = 3'd1,
        HOLD     = 3'd2,
        RISE_BNC = 3'd3,
        GAP      = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;
    logic [CNT_W-1:0]    hold_q,  hold_d;
    logic                bnc_q,   bnc_d;
    logic [LFSR_W-1:0]   lfsr_q,  lfsr_d;
    logic [TICK_W-1:0]   tick_q,  tick_d;
    logic [TOG_W-1:0]    tog_q,   tog_d;
    logic                key_q,   key_d;
    logic                ready_q, ready_d;
    logic                done_q,  done_d;
    logic [PCNT_W-1:0]   pcnt_q,  pcnt_d;

    logic [LFSR_W-1:0]   lfsr_step_c;

    // Tick interval of 1..8 cycles taken from the low LFSR bits.
    function automatic logic [TICK_W-1:0] tick_load(input logic [LFSR_W-1:0] s);
        return TICK_W'(s[2:0]) + TICK_W'(1);
    endfunction

    // Fibonacci LFSR, x^16+x^14+x^13+x^11+1, shift left, feedback into bit 0.
    assign lfsr_step_c = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    // State and datapath registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hold_q  <= '0;
            bnc_q   <= 1'b0;
            lfsr_q  <= LFSR_SEED;
            tick_q  <= '0;
            tog_q   <= '0;
            key_q   <= 1'b1;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            pcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            bnc_q   <= bnc_d;
            lfsr_q  <= lfsr_d;
            tick_q  <= tick_d;
            tog_q   <= tog_d;
            key_q   <= key_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            pcnt_q  <= pcnt_d;
        end
    end

    // Next-state, window timing, bounce ticks and registered output values.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        bnc_d   = bnc_q;
        lfsr_d  = lfsr_q;
        tick_d  = tick_q;
        tog_d   = tog_q;
        key_d   = key_q;
        done_d  = 1'b0;
        pcnt_d  = pcnt_q;

        unique case (state_q)
            IDLE: begin
                key_d = 1'b1;
                if (press_req) begin
                    hold_d  = (hold_cyc == '0) ? CNT_W'(1) : hold_cyc;
                    bnc_d   = bounce_en;
                    cnt_d   = BNC_LOAD;
                    tick_d  = tick_load(lfsr_q);
                    tog_d   = '0;
                    key_d   = 1'b0;
                    state_d = FALL_BNC;
                end
            end

            FALL_BNC, RISE_BNC: begin
                // Chatter: invert the line on each tick until all toggles are spent.
                if (bnc_q && (tog_q != TOG_MAX)) begin
                    if (tick_q == TICK_W'(1)) begin
                        key_d  = ~key_q;
                        lfsr_d = lfsr_step_c;
                        tog_d  = tog_q + TOG_W'(1);
                        tick_d = tick_load(lfsr_step_c);
                    end else begin
                        tick_d = tick_q - TICK_W'(1);
                    end
                end
                if (cnt_q == '0) begin
                    if (state_q == FALL_BNC) begin
                        cnt_d   = hold_q - CNT_W'(1);
                        key_d   = 1'b0;
                        state_d = HOLD;
                    end else begin
                        cnt_d   = GAP_LOAD;
                        key_d   = 1'b1;
                        state_d = GAP;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            HOLD: begin
                if (cnt_q == '0) begin
                    cnt_d   = BNC_LOAD;
                    tick_d  = tick_load(lfsr_q);
                    tog_d   = '0;
                    key_d   = 1'b1;
                    state_d = RISE_BNC;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            GAP: begin
                if (cnt_q == '0) begin
                    done_d  = 1'b1;
                    pcnt_d  = pcnt_q + PCNT_W'(1);
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            default: begin
                key_d   = 1'b1;
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE);
    end

    assign ready     = ready_q;
    assign key_out   = key_q;
    assign done      = done_q;
    assign press_cnt = pcnt_q;

endmodule

// File: doc/key_press_gen.md
# key_press_gen

Stimulus-side counterpart to the board's key-press consumers: on request, it drives an active-low key line through one full press/release cycle with optional contact bounce. It sits between a host or test controller and any raw-key input that uses falling-edge detection, letting the LED/key logic run in simulation and on hardware without a physical button. Bounce timing is pseudo-random (16-bit LFSR) but fully deterministic from reset.

## Interface
- BOUNCE_CYC, default 16'd500: length in cycles of each bounce window (fall and rise); requires BOUNCE_CYC >= 16*BOUNCE_N+1.
- BOUNCE_N, default 4'd5: chatter pairs per bounce window, 0–15.
- GAP_CYC, default 16'd1000: idle-high cycles after release before ready returns; must be >= 1.
- LFSR_SEED, default 16'hACE1: LFSR reset value; must be non-zero.
- sys_clk  in  1  system clock; all logic on posedge.
- sys_rst_n  in  1  asynchronous active-low reset.
- press_req  in  1  press request; accepted on a posedge where press_req=1 and ready=1.
- hold_cyc  in  25  stable-low hold length, latched on accept; 0 is treated as 1.
- bounce_en  in  1  latched on accept; 0 gives clean edges.
- ready  out  1  idle, can accept; reset value 1.
- key_out  out  1  emulated key, idle high, pressed low; registered; reset value 1.
- done  out  1  one-cycle pulse at end of gap; reset value 0.
- press_cnt  out  8  completed presses, wraps 255->0; reset value 0.

## Operation
- FSM states: IDLE, FALL_BNC, HOLD, RISE_BNC, GAP.
- IDLE:
  - key_out=1 and ready=1.
  - On accept, latch hold_cyc (0->1) and bounce_en, then go to FALL_BNC.
- FALL_BNC:
  - key_out=0 on entry.
  - Lasts exactly BOUNCE_CYC cycles, then goes to HOLD.
- HOLD: key_out=0 for exactly the latched hold_cyc cycles, then goes to RISE_BNC.
- RISE_BNC:
  - key_out=1 on entry.
  - Lasts exactly BOUNCE_CYC cycles, then goes to GAP.
- GAP:
  - key_out=1 for GAP_CYC cycles.
  - On exit: done=1 for one cycle, press_cnt+1, ready=1, return to IDLE.
- Bounce, only when bounce_en=1:
  - Each bounce window runs 2*BOUNCE_N toggle ticks, starting at window entry.
  - Tick interval is lfsr[2:0]+1 cycles (1–8).
  - key_out inverts at each tick. The even toggle count returns the line to its entry level. After the last tick, key_out holds that level until the window ends.
  - The LFSR advances once per tick only.
  - LFSR polynomial is x^16+x^14+x^13+x^11+1 (Fibonacci, shift left, feedback into bit 0).
  - The LFSR is not reseeded between presses.
- Falling edges per press on key_out: exactly 1 with bounce_en=0; exactly 2*BOUNCE_N+1 with bounce_en=1.
- press_req while ready=0 is ignored; requests are not queued.
- Changes to hold_cyc or bounce_en after accept have no effect on the current press.
- Reset, asynchronous, in any state, including mid-press:
  - key_out=1, ready=1, done=0, press_cnt=0.
  - LFSR=LFSR_SEED, FSM to IDLE, all counters cleared.

## Timing
- Accept at posedge T:
  - ready=0 and key_out=0 from T+1.
  - FALL_BNC covers T+1..T+BOUNCE_CYC.
  - HOLD covers the next hold_cyc cycles.
  - RISE_BNC covers the next BOUNCE_CYC cycles.
  - GAP covers the next GAP_CYC cycles.
- done=1, ready=1 and the press_cnt update all land in cycle T+1+2*BOUNCE_CYC+hold_cyc+GAP_CYC.
- Clean mode: key_out low for exactly BOUNCE_CYC+hold_cyc cycles.
- Back-to-back: a press_req high on the posedge ending the done cycle is accepted. No idle cycle is required beyond the done cycle.

## Test plan
Parameters for all cases: BOUNCE_CYC=40, BOUNCE_N=2, GAP_CYC=10.
- Clean press, hold_cyc=100, bounce_en=0, accept at T -> key_out=0 over T+1..T+140, 1 at T+141; done/ready=1 at T+191; press_cnt=1; exactly 1 falling edge.
- Bounced press, hold_cyc=100, bounce_en=1 ->
  - 5 falling edges.
  - key_out=0 steadily over T+41..T+140.
  - key_out=1 steadily from the last rise tick through T+190.
  - Toggle intervals match a reference LFSR seeded 16'hACE1.
- hold_cyc=0, bounce_en=0 -> key_out low for exactly 41 cycles; done at T+92.
- press_req held high for three presses -> each accept occurs on the edge after done; press_cnt=3; key_out is idle high for exactly GAP_CYC+1 cycles between presses.
- press_req pulsed during HOLD -> ignored; press_cnt increments by 1 only.
- sys_rst_n pulsed low during HOLD ->
  - key_out=1 and ready=1 immediately, without waiting for a clock edge.
  - press_cnt=0.
  - After release, a new bounced press reproduces the bounce pattern of the first bounced press after reset.
